// File: rtl/keypad_entry_if.sv
// Committed-entry handshake between keypad_entry (master) and the transaction logic (slave).
interface keypad_entry_if #(
  parameter int unsigned DIGITS = 6
);
  logic                  entry_valid;
  logic [4*DIGITS-1:0]   entry_data;
  logic                  entry_ready;

  modport master (output entry_valid, output entry_data, input entry_ready);
  modport slave  (input entry_valid, input entry_data, output entry_ready);
endinterface

// File: rtl/keypad_entry.sv
// Keypad entry: decodes the cursor key on each select press, accumulates a BCD
// amount, and commits it over a valid/ready handshake on '#'.
module keypad_entry #(
  parameter int unsigned DIGITS = 6
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [3:0]          cursor_x,
  input  logic [3:0]          cursor_y,
  input  logic                btn_sel,
  output logic                key_pulse,
  output logic [3:0]          key_code,
  output logic                err_pulse,
  output logic [3:0]          digit_cnt,
  output logic [4*DIGITS-1:0] amount_bcd,
  keypad_entry_if.master      entry
);

  typedef enum logic {ENTRY, HOLD} state_t;

  localparam logic [3:0] KEY_STAR  = 4'hA;
  localparam logic [3:0] KEY_HASH  = 4'hB;
  localparam logic [3:0] KEY_INVAL = 4'hF;
  localparam logic [3:0] MAX_CNT   = 4'(DIGITS);

  state_t                state_q, state_d;
  logic                  btn_sel_q;
  logic                  key_pulse_q, key_pulse_d;
  logic [3:0]            key_code_q, key_code_d;
  logic                  err_pulse_q, err_pulse_d;
  logic [3:0]            digit_cnt_q, digit_cnt_d;
  logic [4*DIGITS-1:0]   amount_q, amount_d;
  logic                  entry_valid_q, entry_valid_d;
  logic [4*DIGITS-1:0]   entry_data_q, entry_data_d;

  logic                  press;
  logic [3:0]            key;

  assign press = !btn_sel && btn_sel_q;

  always_comb begin
    key = KEY_INVAL;
    if (cursor_x <= 4'd2 && cursor_y <= 4'd3) begin
      case ({cursor_y[1:0], cursor_x[1:0]})
        4'b00_00: key = 4'd1;
        4'b00_01: key = 4'd2;
        4'b00_10: key = 4'd3;
        4'b01_00: key = 4'd4;
        4'b01_01: key = 4'd5;
        4'b01_10: key = 4'd6;
        4'b10_00: key = 4'd7;
        4'b10_01: key = 4'd8;
        4'b10_10: key = 4'd9;
        4'b11_00: key = KEY_STAR;
        4'b11_01: key = 4'd0;
        4'b11_10: key = KEY_HASH;
        default:  key = KEY_INVAL;
      endcase
    end
  end

  always_comb begin
    state_d       = state_q;
    key_pulse_d   = 1'b0;
    key_code_d    = key_code_q;
    err_pulse_d   = 1'b0;
    digit_cnt_d   = digit_cnt_q;
    amount_d      = amount_q;
    entry_valid_d = entry_valid_q;
    entry_data_d  = entry_data_q;

    if (state_q == HOLD && entry_valid_q && entry.entry_ready) begin
      entry_valid_d = 1'b0;
      state_d       = ENTRY;
    end

    // Press handling keys off the current state, so a press in the handshake cycle is still a HOLD press.
    if (press) begin
      key_pulse_d = 1'b1;
      key_code_d  = key;
      if (key == KEY_INVAL || state_q == HOLD) begin
        err_pulse_d = 1'b1;
      end else if (key == KEY_STAR) begin
        amount_d    = '0;
        digit_cnt_d = '0;
      end else if (key == KEY_HASH) begin
        if (digit_cnt_q == 4'd0) begin
          err_pulse_d = 1'b1;
        end else begin
          entry_data_d  = amount_q;
          entry_valid_d = 1'b1;
          amount_d      = '0;
          digit_cnt_d   = '0;
          state_d       = HOLD;
        end
      end else if (digit_cnt_q == MAX_CNT) begin
        err_pulse_d = 1'b1;
      end else if (!(key == 4'd0 && digit_cnt_q == 4'd0)) begin
        amount_d    = {amount_q[4*DIGITS-5:0], key};
        digit_cnt_d = digit_cnt_q + 4'd1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= ENTRY;
      btn_sel_q     <= 1'b1;
      key_pulse_q   <= 1'b0;
      key_code_q    <= 4'h0;
      err_pulse_q   <= 1'b0;
      digit_cnt_q   <= '0;
      amount_q      <= '0;
      entry_valid_q <= 1'b0;
      entry_data_q  <= '0;
    end else begin
      state_q       <= state_d;
      btn_sel_q     <= btn_sel;
      key_pulse_q   <= key_pulse_d;
      key_code_q    <= key_code_d;
      err_pulse_q   <= err_pulse_d;
      digit_cnt_q   <= digit_cnt_d;
      amount_q      <= amount_d;
      entry_valid_q <= entry_valid_d;
      entry_data_q  <= entry_data_d;
    end
  end

  assign key_pulse         = key_pulse_q;
  assign key_code          = key_code_q;
  assign err_pulse         = err_pulse_q;
  assign digit_cnt         = digit_cnt_q;
  assign amount_bcd        = amount_q;
  assign entry.entry_valid = entry_valid_q;
  assign entry.entry_data  = entry_data_q;

endmodule

// File: tb/tb_keypad_entry.sv
// Directed bench for keypad_entry: a press/expectation table plus hand-written
// sequences for the handshake, held button and asynchronous reset.
module tb_keypad_entry;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [3:0]  cursor_x = '0;
  logic [3:0]  cursor_y = '0;
  logic        btn_sel = 1'b1;
  logic        key_pulse;
  logic [3:0]  key_code;
  logic        err_pulse;
  logic [3:0]  digit_cnt;
  logic [23:0] amount_bcd;

  keypad_entry_if #(.DIGITS(6)) ent ();

  keypad_entry #(.DIGITS(6)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .cursor_x   (cursor_x),
    .cursor_y   (cursor_y),
    .btn_sel    (btn_sel),
    .key_pulse  (key_pulse),
    .key_code   (key_code),
    .err_pulse  (err_pulse),
    .digit_cnt  (digit_cnt),
    .amount_bcd (amount_bcd),
    .entry      (ent.master)
  );

  always #5 clk = ~clk;

  int unsigned n_vec = 0;
  int unsigned n_err = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Drops btn_sel at a negedge; returns at the following negedge with the press registered.
  task automatic press(input logic [3:0] x, input logic [3:0] y);
    @(negedge clk);
    cursor_x = x;
    cursor_y = y;
    btn_sel  = 1'b0;
    @(negedge clk);
    btn_sel  = 1'b1;
  endtask

  typedef struct {
    logic [3:0]  x;
    logic [3:0]  y;
    logic [3:0]  key;
    logic        err;
    logic [23:0] amt;
    logic [3:0]  cnt;
  } vec_t;

  vec_t vecs [20];

  initial begin
    int unsigned pulses;

    vecs[0]  = '{4'd0, 4'd0, 4'h1, 1'b0, 24'h000001, 4'd1};
    vecs[1]  = '{4'd1, 4'd1, 4'h5, 1'b0, 24'h000015, 4'd2};
    vecs[2]  = '{4'd2, 4'd2, 4'h9, 1'b0, 24'h000159, 4'd3};
    vecs[3]  = '{4'd0, 4'd3, 4'hA, 1'b0, 24'h000000, 4'd0};
    vecs[4]  = '{4'd1, 4'd3, 4'h0, 1'b0, 24'h000000, 4'd0};
    vecs[5]  = '{4'd2, 4'd3, 4'hB, 1'b1, 24'h000000, 4'd0};
    vecs[6]  = '{4'd0, 4'd1, 4'h4, 1'b0, 24'h000004, 4'd1};
    vecs[7]  = '{4'd1, 4'd0, 4'h2, 1'b0, 24'h000042, 4'd2};
    vecs[8]  = '{4'd0, 4'd3, 4'hA, 1'b0, 24'h000000, 4'd0};
    vecs[9]  = '{4'd3, 4'd0, 4'hF, 1'b1, 24'h000000, 4'd0};
    vecs[10] = '{4'd0, 4'd4, 4'hF, 1'b1, 24'h000000, 4'd0};
    vecs[11] = '{4'd0, 4'd0, 4'h1, 1'b0, 24'h000001, 4'd1};
    vecs[12] = '{4'd1, 4'd0, 4'h2, 1'b0, 24'h000012, 4'd2};
    vecs[13] = '{4'd2, 4'd0, 4'h3, 1'b0, 24'h000123, 4'd3};
    vecs[14] = '{4'd0, 4'd1, 4'h4, 1'b0, 24'h001234, 4'd4};
    vecs[15] = '{4'd1, 4'd1, 4'h5, 1'b0, 24'h012345, 4'd5};
    vecs[16] = '{4'd2, 4'd1, 4'h6, 1'b0, 24'h123456, 4'd6};
    vecs[17] = '{4'd0, 4'd2, 4'h7, 1'b1, 24'h123456, 4'd6};
    vecs[18] = '{4'd1, 4'd3, 4'h0, 1'b1, 24'h123456, 4'd6};
    vecs[19] = '{4'd0, 4'd3, 4'hA, 1'b0, 24'h000000, 4'd0};

    ent.entry_ready = 1'b0;

    // Reset state
    repeat (2) @(negedge clk);
    chk("rst key_pulse", 32'(key_pulse), 32'd0);
    chk("rst key_code", 32'(key_code), 32'h0);
    chk("rst err_pulse", 32'(err_pulse), 32'd0);
    chk("rst digit_cnt", 32'(digit_cnt), 32'd0);
    chk("rst amount", 32'(amount_bcd), 32'd0);
    chk("rst entry_valid", 32'(ent.entry_valid), 32'd0);
    chk("rst entry_data", 32'(ent.entry_data), 32'd0);
    rst_n = 1'b1;

    foreach (vecs[i]) begin
      press(vecs[i].x, vecs[i].y);
      chk($sformatf("v%0d key_pulse", i), 32'(key_pulse), 32'd1);
      chk($sformatf("v%0d key_code", i), 32'(key_code), 32'(vecs[i].key));
      chk($sformatf("v%0d err_pulse", i), 32'(err_pulse), 32'(vecs[i].err));
      chk($sformatf("v%0d amount", i), 32'(amount_bcd), 32'(vecs[i].amt));
      chk($sformatf("v%0d digit_cnt", i), 32'(digit_cnt), 32'(vecs[i].cnt));
      chk($sformatf("v%0d entry_valid", i), 32'(ent.entry_valid), 32'd0);
    end

    // Held button at (1,0): one press only
    @(negedge clk);
    cursor_x = 4'd0;
    cursor_y = 4'd1;
    btn_sel  = 1'b0;
    pulses   = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (key_pulse) pulses++;
    end
    chk("hold pulses", pulses, 32'd1);
    chk("hold key_code", 32'(key_code), 32'h4);
    chk("hold amount", 32'(amount_bcd), 32'h000004);
    btn_sel = 1'b1;

    // 0,0,7,# with delayed ready
    press(4'd0, 4'd3);
    press(4'd1, 4'd3);
    press(4'd1, 4'd3);
    chk("lead0 cnt", 32'(digit_cnt), 32'd0);
    chk("lead0 err", 32'(err_pulse), 32'd0);
    press(4'd0, 4'd2);
    chk("pre-commit amount", 32'(amount_bcd), 32'h000007);
    press(4'd2, 4'd3);
    chk("commit valid", 32'(ent.entry_valid), 32'd1);
    chk("commit data", 32'(ent.entry_data), 32'h000007);
    chk("commit amount", 32'(amount_bcd), 32'd0);
    chk("commit cnt", 32'(digit_cnt), 32'd0);
    chk("commit err", 32'(err_pulse), 32'd0);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk($sformatf("wait%0d valid", i), 32'(ent.entry_valid), 32'd1);
    end
    ent.entry_ready = 1'b1;
    @(negedge clk);
    ent.entry_ready = 1'b0;
    chk("handshake valid", 32'(ent.entry_valid), 32'd0);
    chk("handshake data", 32'(ent.entry_data), 32'h000007);

    // ready held high: valid for exactly one cycle
    ent.entry_ready = 1'b1;
    press(4'd2, 4'd0);
    press(4'd2, 4'd3);
    chk("rdy-high valid", 32'(ent.entry_valid), 32'd1);
    chk("rdy-high data", 32'(ent.entry_data), 32'h000003);
    @(negedge clk);
    chk("rdy-high drop", 32'(ent.entry_valid), 32'd0);
    ent.entry_ready = 1'b0;
    press(4'd0, 4'd0);
    chk("back in entry", 32'(amount_bcd), 32'h000001);
    chk("back in entry err", 32'(err_pulse), 32'd0);

    // HOLD rejects presses, then async reset clears the pending entry
    press(4'd2, 4'd3);
    chk("hold commit data", 32'(ent.entry_data), 32'h000001);
    press(4'd1, 4'd2);
    chk("hold press key", 32'(key_code), 32'h8);
    chk("hold press err", 32'(err_pulse), 32'd1);
    chk("hold press data", 32'(ent.entry_data), 32'h000001);
    chk("hold press valid", 32'(ent.entry_valid), 32'd1);
    chk("hold press amount", 32'(amount_bcd), 32'd0);
    #2 rst_n = 1'b0;
    #1;
    chk("arst valid", 32'(ent.entry_valid), 32'd0);
    chk("arst data", 32'(ent.entry_data), 32'd0);
    chk("arst cnt", 32'(digit_cnt), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Async reset mid-entry
    press(4'd1, 4'd2);
    press(4'd2, 4'd2);
    chk("mid amount", 32'(amount_bcd), 32'h000089);
    #2 rst_n = 1'b0;
    #1;
    chk("arst mid amount", 32'(amount_bcd), 32'd0);
    chk("arst mid cnt", 32'(digit_cnt), 32'd0);
    chk("arst mid key_code", 32'(key_code), 32'h0);
    @(negedge clk);
    rst_n = 1'b1;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/keypad_entry.md
# keypad_entry

Consumer side of the POS cursor interface: samples the 3x4 keypad cursor position when the select button is pressed and decodes the key under the cursor. Digits are accumulated into a BCD amount buffer. '*' clears the buffer; '#' commits it through a valid/ready handshake to the transaction logic. The block sits between the cursor controller and the POS register/display datapath.

## Interface
- DIGITS, 6, maximum number of BCD digits in an entry (2..8)
- clk  in  1  system clock, all state on rising edge
- rst_n  in  1  reset; asynchronous, active-low
- cursor_x  in  4  cursor column; valid 0..2
- cursor_y  in  4  cursor row; valid 0..3
- btn_sel  in  1  select button, active-low
- key_pulse  out  1  one-cycle strobe per accepted press, including invalid positions
- key_code  out  4  decoded key, held until the next press: 0-9 digit, 4'hA '*', 4'hB '#', 4'hF invalid position
- err_pulse  out  1  one-cycle strobe for a rejected press
- digit_cnt  out  4  number of digits currently in the buffer
- amount_bcd  out  4*DIGITS  live buffer; least significant digit in [3:0]
- entry_valid  out  1  committed entry available
- entry_data  out  4*DIGITS  committed amount; stable while entry_valid=1
- entry_ready  in  1  downstream accepts entry_data

## Operation
- Key map, (y,x) to key:
  - row 0: 1 2 3
  - row 1: 4 5 6
  - row 2: 7 8 9
  - row 3: * 0 #
- cursor_x>2 or cursor_y>3 gives key_code 4'hF and err_pulse; no state change.
- Press detection:
  - btn_sel_d is a registered copy of btn_sel, reset to 1.
  - A press is a cycle where btn_sel=0 and btn_sel_d=1.
  - The cursor is sampled in that same cycle.
  - Holding the button produces no further presses.
- FSM states: ENTRY (reset state) and HOLD.
- ENTRY, digit key:
  - digit_cnt==DIGITS: rejected, err_pulse, buffer unchanged.
  - digit 0 with digit_cnt==0: leading zero, discarded, no error.
  - Otherwise: amount_bcd <= {amount_bcd[4*DIGITS-5:0], digit}, digit_cnt+1.
- ENTRY, '*': amount_bcd <= 0, digit_cnt <= 0. Not an error, even if the buffer is already empty.
- ENTRY, '#':
  - digit_cnt==0: err_pulse, stay in ENTRY.
  - Otherwise: entry_data <= amount_bcd, entry_valid <= 1, amount_bcd <= 0, digit_cnt <= 0, go to HOLD.
- HOLD:
  - Every press (any key) gives key_pulse with its key_code, plus err_pulse; buffer and entry_data are unchanged.
  - When entry_valid & entry_ready is sampled at a clock edge, entry_valid <= 0 and the FSM returns to ENTRY.
- entry_ready is ignored while entry_valid=0.
- Reset values: key_pulse 0, key_code 4'h0, err_pulse 0, digit_cnt 0, amount_bcd 0, entry_valid 0, entry_data 0, state ENTRY, btn_sel_d 1.
- Asynchronous reset mid-entry or in HOLD discards the buffer and any pending entry.

## Timing
- Press detected in cycle N. At the edge ending cycle N:
  - key_pulse, key_code and err_pulse are registered;
  - the buffer and digit_cnt update.
  - All are visible in cycle N+1; the pulses are high for exactly that one cycle.
- '#' press in cycle N: entry_valid=1 and entry_data valid from cycle N+1; amount_bcd and digit_cnt read 0 from N+1.
- Handshake sampled high in cycle M: entry_valid=0 and state ENTRY from cycle M+1.
- A press in cycle M itself is treated as a HOLD press (rejected).
- Earliest next commit: a digit press in M+1 and a '#' press in M+3 put entry_valid high again in M+4.
- entry_ready may be held high permanently; entry_valid is then high for exactly 1 cycle per commit.
- The cursor inputs are registered upstream. No synchronisation is required in this block beyond the btn_sel_d edge register.

## Test plan
- Reset, then press at (y,x) = (0,0), (1,1), (2,2) -> key_code 1, 5, 9; amount_bcd = 24'h000159; digit_cnt = 3.
- Press 0, 0, 7 from empty, then '#', entry_ready=0 for 5 cycles then 1 -> amount_bcd reads 24'h000007 before the '#'; entry_data = 24'h000007; entry_valid held high for 5 cycles, low one cycle after the handshake; amount_bcd = 0.
- Enter 7 digits with DIGITS=6 (1..7) -> amount_bcd = 24'h123456, digit_cnt = 6; the 7th press gives err_pulse=1 and the buffer is unchanged.
- '#' with an empty buffer, then '*' after entering 4, 2 -> err_pulse on the '#'; no entry_valid; '*' returns amount_bcd = 0, digit_cnt = 0.
- Press with cursor_x=3, then hold btn_sel low for 10 cycles at (1,0) -> first press: key_code 4'hF and err_pulse; held button: exactly one key_pulse, key_code 4.
- Press digit 8 while in HOLD, and assert rst_n low during HOLD -> the press gives err_pulse with entry_data unchanged; reset forces entry_valid=0, entry_data=0, digit_cnt=0 asynchronously.
